fetch_pc_stage: RTL and testbench



---
 rtl/fetch_pc_stage.sv | 84 ++++++++
 tb/tb_fetch_pc_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stage.sv
// Fetch PC register and F/D pipeline register for the five-stage MIPS pipeline.
// Define FETCH_ADDR_CHECK_EN to enable AdEL detection on the fetch address.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_clr,
  input  logic        D_is_jump,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // An inverted instruction-memory window is a configuration error.
  if (IM_LO > IM_HI) begin : g_bad_im_range
    $error("fetch_pc_stage: IM_LO must not exceed IM_HI");
  end

  logic [4:0]  f_exccode;
  logic [31:0] f_instr_eff;

`ifdef FETCH_ADDR_CHECK_EN
  always_comb begin
    f_exccode = EXC_NONE;
    if ((F_pc[1:0] != 2'b00) || (F_pc < IM_LO) || (F_pc > IM_HI)) begin
      f_exccode = EXC_ADEL;
    end
  end

  // A faulting fetch enters D as a nop so it cannot have side effects.
  always_comb begin
    f_instr_eff = instr_in;
    if (f_exccode != EXC_NONE) begin
      f_instr_eff = 32'h0000_0000;
    end
  end
`else
  assign f_exccode   = EXC_NONE;
  assign f_instr_eff = instr_in;
`endif

  // req redirects even under stall; eret_clr only takes effect on an unstalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_pc      <= RESET_PC;
      D_pc      <= RESET_PC;
      D_instr   <= 32'h0000_0000;
      D_exccode <= EXC_NONE;
      D_bd      <= 1'b0;
    end else if (req) begin
      F_pc      <= HANDLER_PC;
      D_pc      <= HANDLER_PC;
      D_instr   <= 32'h0000_0000;
      D_exccode <= EXC_NONE;
      D_bd      <= 1'b0;
    end else if (!stall) begin
      F_pc <= npc;
      D_pc <= F_pc;
      if (eret_clr) begin
        D_instr   <= 32'h0000_0000;
        D_exccode <= EXC_NONE;
        D_bd      <= 1'b0;
      end else begin
        D_instr   <= f_instr_eff;
        D_exccode <= f_exccode;
        D_bd      <= D_is_jump;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed self-checking bench for fetch_pc_stage; expectations follow the
// FETCH_ADDR_CHECK_EN setting of the build.
module tb_fetch_pc_stage;

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic [31:0] instr_in;
  logic        stall;
  logic        req;
  logic        eret_clr;
  logic        D_is_jump;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_exccode;
  logic        D_bd;

  int checkCount = 0;
  int failCount  = 0;

  fetch_pc_stage dut (
    .clk       (clk),
    .reset     (reset),
    .npc       (npc),
    .instr_in  (instr_in),
    .stall     (stall),
    .req       (req),
    .eret_clr  (eret_clr),
    .D_is_jump (D_is_jump),
    .F_pc      (F_pc),
    .D_pc      (D_pc),
    .D_instr   (D_instr),
    .D_exccode (D_exccode),
    .D_bd      (D_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] n, input logic [31:0] ins,
                               input logic st, input logic rq,
                               input logic er, input logic jmp);
    npc       = n;
    instr_in  = ins;
    stall     = st;
    req       = rq;
    eret_clr  = er;
    D_is_jump = jmp;
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkD(input string tag, input logic [31:0] fpc,
                        input logic [31:0] dpc, input logic [31:0] dins,
                        input logic [4:0] exc, input logic bd);
    checkOutput({tag, ".F_pc"}, F_pc, fpc);
    checkOutput({tag, ".D_pc"}, D_pc, dpc);
    checkOutput({tag, ".D_instr"}, D_instr, dins);
    checkOutput({tag, ".D_exccode"}, {27'd0, D_exccode}, {27'd0, exc});
    checkOutput({tag, ".D_bd"}, {31'd0, D_bd}, {31'd0, bd});
  endtask

  initial begin
    logic [31:0] faultInstr;
    logic [4:0]  faultExc;

    reset = 1'b1;
    applyStimulus(32'h3004, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkD("reset", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0);

    // Free-run with npc = F_pc + 4.
    reset = 1'b0;
    step();
    checkD("run0", 32'h3004, 32'h3000, 32'hA000_0000, 5'd0, 1'b0);
    applyStimulus(32'h3008, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("run1", 32'h3008, 32'h3004, 32'hA000_0001, 5'd0, 1'b0);
    applyStimulus(32'h300c, 32'hA000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("run2", 32'h300c, 32'h3008, 32'hA000_0002, 5'd0, 1'b0);
    applyStimulus(32'h3010, 32'hA000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("run3", 32'h3010, 32'h300c, 32'hA000_0003, 5'd0, 1'b0);

    // Stall three edges at F_pc = 0x3010.
    applyStimulus(32'h3014, 32'hA000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkD("stall", 32'h3010, 32'h300c, 32'hA000_0003, 5'd0, 1'b0);
    end
    applyStimulus(32'h3014, 32'hA000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("unstall", 32'h3014, 32'h3010, 32'hA000_0004, 5'd0, 1'b0);
    applyStimulus(32'h3020, 32'hA000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("to3020", 32'h3020, 32'h3014, 32'hA000_0005, 5'd0, 1'b0);

    // req wins over stall.
    applyStimulus(32'h3024, 32'hA000_0006, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    checkD("req", 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0);

    // Misaligned and out-of-range fetches.
    faultExc = ADDR_CHECK ? 5'd4 : 5'd0;
    applyStimulus(32'h3002, 32'hA000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("toMisalign", 32'h3002, 32'h4180, 32'hA000_0007, 5'd0, 1'b0);
    applyStimulus(32'h3040, 32'hA000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    faultInstr = ADDR_CHECK ? 32'h0 : 32'hA000_0008;
    checkD("misalign", 32'h3040, 32'h3002, faultInstr, faultExc, 1'b0);
    applyStimulus(32'h7000, 32'hA000_0009, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("toHigh", 32'h7000, 32'h3040, 32'hA000_0009, 5'd0, 1'b0);
    applyStimulus(32'h3044, 32'hA000_000A, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    faultInstr = ADDR_CHECK ? 32'h0 : 32'hA000_000A;
    checkD("aboveHi", 32'h3044, 32'h7000, faultInstr, faultExc, 1'b0);

    // Delay slot flag.
    applyStimulus(32'h3048, 32'h2408_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkD("bdSet", 32'h3048, 32'h3044, 32'h2408_0001, 5'd0, 1'b1);
    applyStimulus(32'h6ffc, 32'hA000_000B, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("bdClr", 32'h6ffc, 32'h3048, 32'hA000_000B, 5'd0, 1'b0);
    applyStimulus(32'h3100, 32'hA000_000C, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("imHiLegal", 32'h3100, 32'h6ffc, 32'hA000_000C, 5'd0, 1'b0);

    // eret bubble: held under stall, applied on the first free edge.
    applyStimulus(32'h3208, 32'hA000_000D, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checkD("eretStall", 32'h3100, 32'h6ffc, 32'hA000_000C, 5'd0, 1'b0);
    applyStimulus(32'h3208, 32'hA000_000D, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkD("eret", 32'h3208, 32'h3100, 32'h0, 5'd0, 1'b0);

    // Asynchronous reset mid-cycle.
    applyStimulus(32'h320c, 32'hA000_000E, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkD("postEret", 32'h320c, 32'h3208, 32'hA000_000E, 5'd0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset.F_pc", F_pc, 32'h3000);
    checkOutput("asyncReset.D_pc", D_pc, 32'h3000);
    checkOutput("asyncReset.D_instr", D_instr, 32'h0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
